// File: rtl/swd_host_pkg.sv
// Shared definitions for the SWD host: op codes, ACK codes, FSM states,
// wire-sequence constants and the request-byte helper.
package swd_host_pkg;

    localparam logic [1:0] OP_XFER = 2'b00;
    localparam logic [1:0] OP_LRST = 2'b01;
    localparam logic [1:0] OP_J2S  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    typedef logic [3:0] state_t;
    localparam state_t S_IDLE     = 4'd0;
    localparam state_t S_REQ      = 4'd1;
    localparam state_t S_TRN1     = 4'd2;
    localparam state_t S_ACK      = 4'd3;
    localparam state_t S_RDATA    = 4'd4;
    localparam state_t S_TRN2     = 4'd5;
    localparam state_t S_WDATA    = 4'd6;
    localparam state_t S_IDLE_CYC = 4'd7;
    localparam state_t S_LRST     = 4'd8;
    localparam state_t S_J2S      = 4'd9;
    localparam state_t S_RESP     = 4'd10;

    localparam int          LINE_RESET_LEN = 56;
    localparam logic [15:0] JTAG2SWD_SEQ   = 16'hE79E;

    typedef struct packed {
        logic [1:0]  op;
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    // Bit 0 goes on the wire first: start, APnDP, RnW, A2, A3, parity,
    // stop, park.
    function automatic logic [7:0] req_byte(input logic apndp,
                                            input logic rnw,
                                            input logic [1:0] addr);
        return {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1],
                addr[1], addr[0], rnw, apndp, 1'b1};
    endfunction

endpackage

// File: rtl/swd_host_if.sv
// Command/response handshake bundle between a requester and swd_host.
// master: issues commands, consumes responses. slave: the SWD host.
interface swd_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_apndp;
    logic        cmd_rnw;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_perr;

    modport master (
        output cmd_valid, cmd_op, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_apndp, cmd_rnw, cmd_addr, cmd_wdata,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr
    );
endinterface

// File: rtl/swd_clk_gen.sv
// SWCLK divider: half-period of CLK_DIV clk cycles while run is high.
// Ports: clk, rst, run in; swclk, rise_tick, fall_tick (1-cycle strobes
// on the cycle whose edge produces the SWCLK transition) out.
module swd_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic swclk,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          armed;
    logic          wrap;

    // armed delays counting by one cycle so the first rising edge lands
    // CLK_DIV+1 cycles after run goes high, giving bit 0 a full setup.
    assign wrap      = run && armed && (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = wrap && !swclk;
    assign fall_tick = wrap && swclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
            swclk <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            armed <= 1'b0;
            swclk <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (armed) begin
                if (wrap) begin
                    cnt   <= '0;
                    swclk <= ~swclk;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/swd_host.sv
// SWD probe-side host: turns one queued command into an SWD wire sequence
// (transfer, line reset, JTAG-to-SWD) and returns ACK/rdata/parity status.
// Ports: fpga_clk_in, fpga_rst_in; bus (swd_host_if.slave) for cmd/rsp;
// swclk, swdio_out, swdio_oe, swdio_in pad signals.
// Build option: SWD_HOST_WAIT_RETRY_EN re-issues a WAITed request.
module swd_host
    import swd_host_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int IDLE_CYCLES = 2,
    parameter int MAX_RETRY   = 15
) (
    input  logic         fpga_clk_in,
    input  logic         fpga_rst_in,
    swd_host_if.slave    bus,
    output logic         swclk,
    output logic         swdio_out,
    output logic         swdio_oe,
    input  logic         swdio_in
);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t      state;
    cmd_t        cmd;
    logic [1:0]  sync;
    logic        din;
    logic [6:0]  bitcnt;
    logic [31:0] sh;
    logic [32:0] rx;
    logic [2:0]  ack;
    logic [2:0]  ack_now;
    logic [RW-1:0] retry;
    logic [7:0]  len;
    logic        run, rise, fall, rose, step, last;
    logic        retry_go, ok_read;

    swd_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk       (fpga_clk_in),
        .rst       (fpga_rst_in),
        .run       (run),
        .swclk     (swclk),
        .rise_tick (rise),
        .fall_tick (fall)
    );

    assign din     = sync[1];
    assign run     = (state != S_IDLE) && (state != S_RESP);
    // A bit period ends on a falling edge that followed a rising edge.
    assign step    = fall && rose;
    assign ack_now = {din, ack[2:1]};
    assign ok_read = (cmd.op == OP_XFER) && (ack == ACK_OK) && cmd.rnw;
    assign last    = (bitcnt == 7'(len - 8'd1));

    assign bus.cmd_ready = (state == S_IDLE);
    assign swdio_oe = (state == S_REQ) || (state == S_WDATA) ||
                      (state == S_IDLE_CYC) || (state == S_LRST) ||
                      (state == S_J2S);

`ifdef SWD_HOST_WAIT_RETRY_EN
    assign retry_go = (cmd.op == OP_XFER) && (ack == ACK_WAIT) &&
                      (retry < RW'(MAX_RETRY));
`else
    assign retry_go = 1'b0;
`endif

    always_comb begin
        len = 8'd1;
        case (state)
            S_REQ:      len = 8'd8;
            S_ACK:      len = 8'd3;
            S_RDATA:    len = 8'd33;
            S_WDATA:    len = 8'd33;
            S_IDLE_CYC: len = 8'(IDLE_CYCLES);
            S_LRST:     len = 8'(LINE_RESET_LEN);
            S_J2S:      len = 8'(2 * LINE_RESET_LEN + 16);
            default:    len = 8'd1;
        endcase
    end

    // Wire value of bit i of the ones / E79E / ones switch sequence.
    function automatic logic j2s_bit(input logic [6:0] i);
        logic [6:0] k;
        k = i - 7'(LINE_RESET_LEN);
        if (i >= 7'(LINE_RESET_LEN) && i < 7'(LINE_RESET_LEN + 16))
            return JTAG2SWD_SEQ[k[3:0]];
        return 1'b1;
    endfunction

    always_ff @(posedge fpga_clk_in or posedge fpga_rst_in) begin
        if (fpga_rst_in) begin
            state         <= S_IDLE;
            cmd           <= '0;
            sync          <= 2'b00;
            bitcnt        <= '0;
            sh            <= '0;
            rx            <= '0;
            ack           <= '0;
            retry         <= '0;
            rose          <= 1'b0;
            swdio_out     <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_ack   <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_perr  <= 1'b0;
        end else begin
            sync <= {sync[0], swdio_in};
            if (rise) rose <= 1'b1;
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    cmd       <= '{bus.cmd_op, bus.cmd_apndp, bus.cmd_rnw,
                                   bus.cmd_addr, bus.cmd_wdata};
                    bitcnt    <= '0;
                    ack       <= '0;
                    retry     <= '0;
                    rose      <= 1'b0;
                    swdio_out <= 1'b1;
                    unique case (bus.cmd_op)
                        OP_XFER: begin
                            state <= S_REQ;
                            sh    <= {24'd0, req_byte(bus.cmd_apndp,
                                                      bus.cmd_rnw,
                                                      bus.cmd_addr)};
                        end
                        OP_LRST: state <= S_LRST;
                        OP_J2S:  state <= S_J2S;
                        OP_RSVD: begin
                            state        <= S_RESP;
                            bus.rsp_ack  <= '0;
                            bus.rsp_perr <= 1'b0;
                        end
                    endcase
                end
                S_RESP: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: if (step) begin
                    rose   <= 1'b0;
                    bitcnt <= last ? 7'd0 : bitcnt + 7'd1;
                    unique case (state)
                        S_REQ: begin
                            if (last) begin
                                state <= S_TRN1;
                            end else begin
                                swdio_out <= sh[1];
                                sh        <= sh >> 1;
                            end
                        end
                        S_TRN1: state <= S_ACK;
                        S_ACK: begin
                            ack <= ack_now;
                            if (last)
                                state <= (ack_now == ACK_OK && cmd.rnw) ?
                                         S_RDATA : S_TRN2;
                        end
                        S_RDATA: begin
                            rx <= {din, rx[32:1]};
                            if (last) state <= S_TRN2;
                        end
                        S_TRN2: begin
                            if (ack == ACK_OK && !cmd.rnw) begin
                                state     <= S_WDATA;
                                sh        <= cmd.wdata;
                                swdio_out <= cmd.wdata[0];
                            end else begin
                                state     <= S_IDLE_CYC;
                                swdio_out <= 1'b0;
                            end
                        end
                        S_WDATA: begin
                            if (last) begin
                                state     <= S_IDLE_CYC;
                                swdio_out <= 1'b0;
                            end else if (bitcnt == 7'd31) begin
                                swdio_out <= ^cmd.wdata;
                            end else begin
                                swdio_out <= sh[1];
                                sh        <= sh >> 1;
                            end
                        end
                        S_IDLE_CYC: begin
                            if (last) begin
                                swdio_out <= 1'b1;
                                if (retry_go) begin
                                    state <= S_REQ;
                                    retry <= retry + 1'b1;
                                    sh    <= {24'd0, req_byte(cmd.apndp,
                                                              cmd.rnw,
                                                              cmd.addr)};
                                end else begin
                                    state        <= S_RESP;
                                    bus.rsp_ack  <= (cmd.op == OP_XFER) ?
                                                    ack : 3'b000;
                                    bus.rsp_perr <= ok_read &&
                                                    (rx[32] != ^rx[31:0]);
                                    if (ok_read)
                                        bus.rsp_rdata <= rx[31:0];
                                end
                            end
                        end
                        S_LRST: begin
                            if (last) begin
                                state     <= S_IDLE_CYC;
                                swdio_out <= 1'b0;
                            end
                        end
                        S_J2S: begin
                            if (last) begin
                                state     <= S_IDLE_CYC;
                                swdio_out <= 1'b0;
                            end else begin
                                swdio_out <= j2s_bit(bitcnt + 7'd1);
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            endcase
        end
    end
endmodule
